compute_unit: RTL
=================

Name: compute_unit

Overview:
- Parametrised, address-mapped arithmetic coprocessor; next generation of the single-shot adder/compare computing device.
- Sits on the CPU peripheral bus. Software writes two operands and an opcode, polls STATUS (or takes an IRQ), then reads a double-width result.
- Operations: add, subtract, unsigned/signed compare, and a multi-cycle iterative unsigned multiply.
- Read data is forced to zero when the block is not selected, so o_data can be OR-combined with other devices.

Parameters:
- DATA_WIDTH, 16, bus/operand width (matches `DATA_WIDTH`); legal range 8..32.
- BASE_ADDR, 16'h0040, address of register offset 0. Block decodes BASE_ADDR..BASE_ADDR+5.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- device_en  in  1  block select; no access without it.
- wr_en  in  1  write strobe, qualified by device_en.
- rd_en  in  1  read strobe, qualified by device_en.
- address  in  DATA_WIDTH  register address.
- i_data  in  DATA_WIDTH  write data.
- o_data  out  DATA_WIDTH  read data; combinational; zero unless device_en & rd_en & address in range.

Behaviour:
- Clocking/reset: one clock domain (clk); reset asynchronous, active-low (rst_n). Reset clears all registers, FSM=IDLE, o_data=0, irq=0.
- Register map (offset: name, access):
  - 0: OPA, RW.
  - 1: OPB, RW.
  - 2: CTRL, W. Bits [2:0] = opcode; a write starts an operation. Reads return the last opcode.
  - 3: STATUS, R. bit0 busy, bit1 done, bit2 err; reading clears done and err.
  - 4: RES_LO, R.
  - 5: RES_HI, R.
- Opcodes:
  - 0 ADD: RES_LO = A+B; RES_HI = {0, carry}.
  - 1 SUB: RES_LO = A-B; RES_HI = {0, borrow}.
  - 2 CMPU: RES_LO = {0, gt, lt, eq}, unsigned; RES_HI = 0.
  - 3 CMPS: same encoding, two's-complement; RES_HI = 0.
  - 4 MUL: unsigned {RES_HI, RES_LO} = A*B.
  - 5–7 reserved: result = 0, err = 1, done = 1.
- FSM states: IDLE, EXEC, MULT, DONE.
  - IDLE: a CTRL write in cycle N latches the operands and goes to EXEC (opcodes 0–3, 5–7) or MULT (opcode 4) at edge N; busy = 1 from cycle N+1.
  - EXEC: one cycle; result registers written; moves to DONE.
  - MULT: shift-add, one multiplier bit per cycle, a DATA_WIDTH-bit counter. Exits after exactly DATA_WIDTH cycles; result written on the last cycle.
  - DONE: one cycle; sets done, clears busy, returns to IDLE.
- Latency from CTRL write to done visible in STATUS:
  - ADD/SUB/CMP/reserved: 2 cycles.
  - MUL: DATA_WIDTH+1 cycles.
- Busy rules:
  - Writes to OPA/OPB/CTRL while busy are ignored and set err; operand, result and FSM are unaffected.
  - Results stay stable until the next accepted start. RES registers update only on the final compute cycle.
- Simultaneous events:
  - STATUS read in the same cycle done/err is being set: the set wins and the bit stays 1.
  - Start accepted in the same cycle as a STATUS read: done clears.
  - wr_en and rd_en both high: both take effect; the read returns the pre-write value.
- Out-of-range address or device_en = 0: no state change, o_data = 0.
- Reset mid-operation: immediate abort; all registers return to reset values; no done, no irq.
- Width: all arithmetic is modulo DATA_WIDTH; the multiplier accumulator is 2*DATA_WIDTH.

Optional Feature:
- Macro: COMPUTE_UNIT_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit, reset 0).
  - Adds CTRL bit3 = irq_en, stored in a separate register that is written on every accepted CTRL write.
  - irq = done & irq_en, level; it drops when STATUS is read.
- Undefined: no irq port; CTRL bit3 is ignored and reads 0.

Test Plan (DATA_WIDTH=16, BASE_ADDR=16'h0040):
- OPA=FFFF, OPB=0001, CTRL=0 -> 2 cycles later STATUS=0002; RES_LO=0000, RES_HI=0001; next STATUS read = 0000.
- OPA=0003, OPB=0005, CTRL=1 -> RES_LO=FFFE, RES_HI=0001. OPA=8000, OPB=0001: CTRL=3 gives RES_LO=0002, CTRL=2 gives RES_LO=0004.
- OPA=1234, OPB=00FF, CTRL=4 -> busy for exactly 16 cycles; at cycle 17 STATUS=0002, RES_LO=21CC, RES_HI=0012.
- During MUL, write OPA=0000 and CTRL=0 -> ignored; final result still 0012_21CC; STATUS=0006.
- CTRL=7 -> STATUS=0006, RES_LO=0000. Read of address 0046 or device_en=0 -> o_data=0000, no state change.
- rst_n low at MUL cycle 8 -> all registers 0, busy=0. With COMPUTE_UNIT_IRQ_EN defined, CTRL=0x8 (ADD, irq_en): irq=1 at done, irq=0 after the STATUS read.

Source files
------------

// File: rtl/compute_unit.sv
// Address-mapped arithmetic coprocessor: add/sub/compare in one cycle, shift-add multiply.
// Optional interrupt output enabled by defining COMPUTE_UNIT_IRQ_EN.
module compute_unit #(
    parameter int unsigned            DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0]  BASE_ADDR  = DATA_WIDTH'(16'h0040)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  device_en,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
`ifdef COMPUTE_UNIT_IRQ_EN
    ,
    output logic                  irq
`endif
);
    localparam int unsigned W = DATA_WIDTH;

    localparam logic [2:0] OffOpa    = 3'd0;
    localparam logic [2:0] OffOpb    = 3'd1;
    localparam logic [2:0] OffCtrl   = 3'd2;
    localparam logic [2:0] OffStatus = 3'd3;
    localparam logic [2:0] OffResLo  = 3'd4;
    localparam logic [2:0] OffResHi  = 3'd5;

    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpSub  = 3'd1;
    localparam logic [2:0] OpCmpu = 3'd2;
    localparam logic [2:0] OpCmps = 3'd3;
    localparam logic [2:0] OpMul  = 3'd4;

    typedef enum logic [1:0] {StIdle, StExec, StMult, StDone} state_e;

    state_e           r_state;
    logic [W-1:0]     r_opa;
    logic [W-1:0]     r_opb;
    logic [2:0]       r_op;
    logic             r_done;
    logic             r_err;
    logic [W-1:0]     r_res_lo;
    logic [W-1:0]     r_res_hi;
    logic [2*W-1:0]   r_acc;
    logic [2*W-1:0]   r_mcand;
    logic [W-1:0]     r_mplier;
    logic [W-1:0]     r_cnt;
`ifdef COMPUTE_UNIT_IRQ_EN
    logic             r_irq_en;
`endif

    // Address decode: offset wraps for addresses below BASE_ADDR, so one compare suffices.
    logic [W-1:0] w_off;
    logic [2:0]   w_idx;
    logic         w_hit, w_wr, w_rd, w_busy;
    logic         w_wr_opa, w_wr_opb, w_wr_ctrl, w_start, w_busy_wr, w_stat_rd;

    assign w_off     = address - BASE_ADDR;
    assign w_hit     = (w_off < W'(6));
    assign w_idx     = w_off[2:0];
    assign w_wr      = device_en & wr_en & w_hit;
    assign w_rd      = device_en & rd_en & w_hit;
    assign w_busy    = (r_state == StExec) || (r_state == StMult);
    assign w_wr_opa  = w_wr && (w_idx == OffOpa);
    assign w_wr_opb  = w_wr && (w_idx == OffOpb);
    assign w_wr_ctrl = w_wr && (w_idx == OffCtrl);
    assign w_start   = w_wr_ctrl && !w_busy;
    assign w_busy_wr = w_busy && (w_wr_opa || w_wr_opb || w_wr_ctrl);
    assign w_stat_rd = w_rd && (w_idx == OffStatus);

    logic [W:0] w_sum, w_diff;
    logic       w_eq, w_lt_u, w_lt_s;

    assign w_sum  = {1'b0, r_opa} + {1'b0, r_opb};
    assign w_diff = {1'b0, r_opa} - {1'b0, r_opb};
    assign w_eq   = (r_opa == r_opb);
    assign w_lt_u = (r_opa < r_opb);
    assign w_lt_s = ($signed(r_opa) < $signed(r_opb));

    logic [W-1:0] w_exec_lo, w_exec_hi;
    logic         w_exec_err;

    always_comb begin
        w_exec_lo  = '0;
        w_exec_hi  = '0;
        w_exec_err = 1'b0;
        case (r_op)
            OpAdd: begin
                w_exec_lo = w_sum[W-1:0];
                w_exec_hi = W'(w_sum[W]);
            end
            OpSub: begin
                w_exec_lo = w_diff[W-1:0];
                w_exec_hi = W'(w_diff[W]);
            end
            OpCmpu: w_exec_lo = W'({!w_lt_u && !w_eq, w_lt_u, w_eq});
            OpCmps: w_exec_lo = W'({!w_lt_s && !w_eq, w_lt_s, w_eq});
            default: w_exec_err = 1'b1;
        endcase
    end

    logic [2*W-1:0] w_acc_next;
    logic           w_mul_last;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_last = (r_cnt == W'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_opa    <= '0;
            r_opb    <= '0;
            r_op     <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
`ifdef COMPUTE_UNIT_IRQ_EN
            r_irq_en <= 1'b0;
`endif
        end else begin
            if (w_wr_opa && !w_busy) r_opa <= i_data;
            if (w_wr_opb && !w_busy) r_opb <= i_data;

            // Clears come first so that a same-cycle set overrides them.
            if (w_stat_rd || w_start) r_done <= 1'b0;
            if (w_stat_rd)            r_err  <= 1'b0;
            if (w_busy_wr)            r_err  <= 1'b1;

            case (r_state)
                StIdle, StDone: begin
                    r_state <= StIdle;
                    if (w_start) begin
                        r_op <= i_data[2:0];
`ifdef COMPUTE_UNIT_IRQ_EN
                        r_irq_en <= i_data[3];
`endif
                        if (i_data[2:0] == OpMul) begin
                            r_acc    <= '0;
                            r_mcand  <= {{W{1'b0}}, r_opa};
                            r_mplier <= r_opb;
                            r_cnt    <= '0;
                            r_state  <= StMult;
                        end else begin
                            r_state  <= StExec;
                        end
                    end
                end
                StExec: begin
                    r_res_lo <= w_exec_lo;
                    r_res_hi <= w_exec_hi;
                    r_done   <= 1'b1;
                    if (w_exec_err) r_err <= 1'b1;
                    r_state  <= StDone;
                end
                StMult: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + W'(1);
                    if (w_mul_last) begin
                        r_res_lo <= w_acc_next[W-1:0];
                        r_res_hi <= w_acc_next[2*W-1:W];
                        r_done   <= 1'b1;
                        r_state  <= StDone;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_data = '0;
        if (w_rd) begin
            case (w_idx)
                OffOpa:    o_data = r_opa;
                OffOpb:    o_data = r_opb;
`ifdef COMPUTE_UNIT_IRQ_EN
                OffCtrl:   o_data = W'({r_irq_en, r_op});
`else
                OffCtrl:   o_data = W'(r_op);
`endif
                OffStatus: o_data = W'({r_err, r_done, w_busy});
                OffResLo:  o_data = r_res_lo;
                OffResHi:  o_data = r_res_hi;
                default:   o_data = '0;
            endcase
        end
    end

`ifdef COMPUTE_UNIT_IRQ_EN
    assign irq = r_done & r_irq_en;
`endif

endmodule
